// File: rtl/series_to_parallel_10_hrx2.sv
// series_to_parallel_10_hrx2
// Reassembles the two-beat half-rate series output of the 10-element vector
// adder (five signed sums per beat) into one registered 10-element vector.
// Beat 0 is parked in a low buffer; beat 1 completes the vector and loads
// all of Y0..Y9 on the same edge, together with a one-cycle outReady strobe.
// Optional feature macro: SERIES_ORDER_CHECK_EN (honour inSeries, flag
// out-of-order beats on the sticky seqError output).

// Per-element slice: one low-buffer entry plus the Y pair it feeds.
module s2p_lane #(
  parameter int SW = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_lo,
  input  logic          complete,
  input  logic [SW-1:0] s,
  output logic [SW-1:0] y_lo,
  output logic [SW-1:0] y_hi
);
  logic [SW-1:0] lo_buf;

  // Park the low beat; on completion move it to y_lo and the high beat to y_hi.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo_buf <= '0;
      y_lo   <= '0;
      y_hi   <= '0;
    end else begin
      if (load_lo) lo_buf <= s;
      if (complete) begin
        y_lo <= lo_buf;
        y_hi <= s;
      end
    end
  end
endmodule

module series_to_parallel_10_hrx2 #(
  parameter int IN_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       inReady,
  input  logic                       inSeries,
  input  logic signed [IN_WIDTH:0]   S0,
  input  logic signed [IN_WIDTH:0]   S1,
  input  logic signed [IN_WIDTH:0]   S2,
  input  logic signed [IN_WIDTH:0]   S3,
  input  logic signed [IN_WIDTH:0]   S4,
  output logic                       readyForNewDataSeries,
  output logic signed [IN_WIDTH:0]   Y0,
  output logic signed [IN_WIDTH:0]   Y1,
  output logic signed [IN_WIDTH:0]   Y2,
  output logic signed [IN_WIDTH:0]   Y3,
  output logic signed [IN_WIDTH:0]   Y4,
  output logic signed [IN_WIDTH:0]   Y5,
  output logic signed [IN_WIDTH:0]   Y6,
  output logic signed [IN_WIDTH:0]   Y7,
  output logic signed [IN_WIDTH:0]   Y8,
  output logic signed [IN_WIDTH:0]   Y9,
  output logic                       outReady,
  output logic                       earlyOutReady,
  output logic                       seqError
);
  localparam int SW    = IN_WIDTH + 1;
  localparam int LANES = 5;

  typedef enum logic {LO = 1'b0, HI = 1'b1} state_t;

  state_t state, state_nxt;
  logic   accept, load_lo, complete, set_err;
  logic   out_q;

  logic [LANES-1:0][SW-1:0] s_vec, y_lo, y_hi;

  assign s_vec  = {S4, S3, S2, S1, S0};
  assign accept = enable & inReady;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LO;
    else        state <= state_nxt;
  end

  // Next state and beat steering; nothing moves unless a beat is accepted.
  always_comb begin
    state_nxt = state;
    load_lo   = 1'b0;
    complete  = 1'b0;
    set_err   = 1'b0;
    if (accept) begin
`ifdef SERIES_ORDER_CHECK_EN
      case (state)
        LO: begin
          if (!inSeries) begin
            load_lo   = 1'b1;
            state_nxt = HI;
          end else begin
            set_err   = 1'b1;          // high beat with no low half: drop it
          end
        end
        HI: begin
          if (inSeries) begin
            complete  = 1'b1;
            state_nxt = LO;
          end else begin
            load_lo   = 1'b1;          // fresh low half restarts the series
            set_err   = 1'b1;
          end
        end
        default: state_nxt = LO;
      endcase
`else
      case (state)
        LO: begin
          load_lo   = 1'b1;
          state_nxt = HI;
        end
        HI: begin
          complete  = 1'b1;
          state_nxt = LO;
        end
        default: state_nxt = LO;
      endcase
`endif
    end
  end

  // Completion strobe, registered alongside Y so both change on one edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out_q <= 1'b0;
    else        out_q <= complete;
  end

`ifdef SERIES_ORDER_CHECK_EN
  logic err_q;
  // Sticky order-error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       err_q <= 1'b0;
    else if (set_err) err_q <= 1'b1;
  end
  assign seqError = err_q;
`else
  logic unused_series;
  assign unused_series = inSeries ^ set_err;
  assign seqError      = 1'b0;
`endif

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      s2p_lane #(.SW(SW)) u_lane (
        .clk      (clk),
        .reset    (reset),
        .load_lo  (load_lo),
        .complete (complete),
        .s        (s_vec[g]),
        .y_lo     (y_lo[g]),
        .y_hi     (y_hi[g])
      );
    end
  endgenerate

  assign Y0 = y_lo[0];
  assign Y1 = y_lo[1];
  assign Y2 = y_lo[2];
  assign Y3 = y_lo[3];
  assign Y4 = y_lo[4];
  assign Y5 = y_hi[0];
  assign Y6 = y_hi[1];
  assign Y7 = y_hi[2];
  assign Y8 = y_hi[3];
  assign Y9 = y_hi[4];

  assign outReady              = out_q;
  assign earlyOutReady         = complete;
  assign readyForNewDataSeries = (state == LO);
endmodule

// File: tb/tb_series_to_parallel_10_hrx2.sv
// Self-checking bench for series_to_parallel_10_hrx2: directed steps from the
// test plan followed by a randomized beat stream, all compared against a
// pending-low-half reference model. Honours SERIES_ORDER_CHECK_EN.
module tb_series_to_parallel_10_hrx2;
  localparam int IW = 10;
  localparam int W  = IW + 1;
`ifdef SERIES_ORDER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b0, enable = 1'b0, inReady = 1'b0, inSeries = 1'b0;
  logic signed [W-1:0] sv [5];
  logic signed [W-1:0] Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, Y8, Y9;
  logic readyForNewDataSeries, outReady, earlyOutReady, seqError;

  int checks = 0, failures = 0;

  // reference model: is a low half pending, what it holds, expected outputs
  bit                  have_low;
  logic signed [W-1:0] low_v [5];
  logic signed [W-1:0] ey [10];
  bit                  eout, eerr;

  series_to_parallel_10_hrx2 #(.IN_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .inReady(inReady), .inSeries(inSeries),
    .S0(sv[0]), .S1(sv[1]), .S2(sv[2]), .S3(sv[3]), .S4(sv[4]),
    .readyForNewDataSeries(readyForNewDataSeries),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3), .Y4(Y4),
    .Y5(Y5), .Y6(Y6), .Y7(Y7), .Y8(Y8), .Y9(Y9),
    .outReady(outReady), .earlyOutReady(earlyOutReady), .seqError(seqError)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [10*W-1:0] obs, input logic [10*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [10*W-1:0] exp_y();
    logic [10*W-1:0] e;
    for (int i = 0; i < 10; i++) e[i*W +: W] = ey[i];
    return e;
  endfunction

  function automatic logic [4:0][W-1:0] ramp(input int base);
    logic [4:0][W-1:0] v;
    for (int i = 0; i < 5; i++) v[i] = W'(base + i);
    return v;
  endfunction

  function automatic logic [4:0][W-1:0] fill(input int x);
    logic [4:0][W-1:0] v;
    for (int i = 0; i < 5; i++) v[i] = W'(x);
    return v;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".outReady"}, outReady, eout);
    chk({tag, ".Y"}, {Y9, Y8, Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0}, exp_y());
    chk({tag, ".seqError"}, seqError, eerr);
  endtask

  // One cycle of stimulus: drive at negedge, check combinational outputs,
  // advance the model across the rising edge, check registered outputs.
  task automatic step(input string tag, input bit en, input bit rdy, input bit ser,
                      input logic [4:0][W-1:0] v);
    bit acc, early;
    @(negedge clk);
    enable = en; inReady = rdy; inSeries = ser;
    for (int i = 0; i < 5; i++) sv[i] = v[i];
    acc   = en && rdy;
    early = acc && have_low && (ser || !CHK);
    #1;
    chk({tag, ".early"}, earlyOutReady, early);
    chk({tag, ".rfnds"}, readyForNewDataSeries, !have_low);
    @(posedge clk);
    #1;
    eout = early;
    if (acc) begin
      if (early) begin
        for (int i = 0; i < 5; i++) begin
          ey[i]     = low_v[i];
          ey[i + 5] = v[i];
        end
        have_low = 1'b0;
      end else if (!CHK || !ser) begin
        if (have_low) eerr = 1'b1;   // only reachable with the check enabled
        for (int i = 0; i < 5; i++) low_v[i] = v[i];
        have_low = 1'b1;
      end else begin
        eerr = 1'b1;                 // high beat with nothing pending
      end
    end
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag, 1'b1, 1'b0, 1'b0, fill(0));
  endtask

  // Asynchronous reset pulse away from the clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0; inReady = 1'b0; enable = 1'b0;
    #1;
    have_low = 1'b0; eout = 1'b0; eerr = 1'b0;
    for (int i = 0; i < 10; i++) ey[i] = '0;
    for (int i = 0; i < 5; i++) low_v[i] = '0;
    check_outputs(tag);
    chk({tag, ".rfnds"}, readyForNewDataSeries, 1'b1);
    chk({tag, ".early"}, earlyOutReady, 1'b0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bit en, rdy, ser;
    for (int i = 0; i < 5; i++) sv[i] = '0;

    do_reset("reset");

    // basic pair 1..10, strobe exactly one cycle
    step("basic_lo", 1, 1, 0, ramp(1));
    step("basic_hi", 1, 1, 1, ramp(6));
    idle("basic_after", 2);

    // signed extremes
    step("ext_lo", 1, 1, 0, fill(-1024));
    step("ext_hi", 1, 1, 1, fill(1023));
    idle("ext_after", 1);

    // gaps and enable
    step("gap_lo", 1, 1, 0, ramp(1));
    idle("gap_idle", 3);
    step("gap_hi_dis", 0, 1, 1, ramp(6));
    step("gap_hi_en", 1, 1, 1, ramp(6));
    idle("gap_after", 1);

    // back-to-back vectors 1..10 then 11..20
    step("b2b_0", 1, 1, 0, ramp(1));
    step("b2b_1", 1, 1, 1, ramp(6));
    step("b2b_2", 1, 1, 0, ramp(11));
    step("b2b_3", 1, 1, 1, ramp(16));
    idle("b2b_after", 1);

    // reset mid-series discards the low half
    step("mid_lo", 1, 1, 0, ramp(1));
    do_reset("mid_reset");
    step("mid_lo2", 1, 1, 0, ramp(21));
    step("mid_hi2", 1, 1, 1, ramp(26));
    idle("mid_after", 1);

    // out-of-order high beat while nothing is pending
    step("ord_hi_in_lo", 1, 1, 1, ramp(31));
    step("ord_lo", 1, 1, 0, ramp(36));
    step("ord_hi", 1, 1, 1, ramp(41));
    idle("ord_after", 2);
    do_reset("ord_reset");

    // randomized stream, mostly well-ordered with occasional order errors
    for (int n = 0; n < 400; n++) begin
      logic [4:0][W-1:0] v;
      en  = ($urandom % 8) != 0;
      rdy = ($urandom % 3) != 0;
      ser = have_low ? (($urandom % 6) != 0) : (($urandom % 6) == 0);
      for (int i = 0; i < 5; i++) v[i] = W'($urandom);
      step("rand", en, rdy, ser, v);
      if (n == 200) do_reset("rand_reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/series_to_parallel_10_hrx2.md
# series_to_parallel_10_hrx2

Reassembles the half-rate, two-beat series output of the 10-element vector adder (five signed sums per beat) into one registered 10-element parallel vector. Sits directly downstream of the series-mode vector add stage. Its parallel output feeds parallel-input consumers such as later linear-algebra stages, and it gives them a single-cycle completion strobe.

## Interface
- IN_WIDTH, 10, operand width of the upstream adder; data ports here are IN_WIDTH+1 bits (sum width)

- clk  input  1  clock, all registers on rising edge
- reset  input  1  asynchronous, active-low reset
- enable  input  1  clock-enable; 0 freezes all state
- inReady  input  1  beat valid; S0..S4 and inSeries sampled when high
- inSeries  input  1  beat index: 0 = elements 0-4, 1 = elements 5-9
- S0, S1, S2, S3, S4  input  IN_WIDTH+1 each, signed  beat data
- readyForNewDataSeries  output  1  high while expecting the first (inSeries=0) beat
- Y0 … Y9  output  IN_WIDTH+1 each, signed  reassembled vector, registered
- outReady  output  1  one-cycle strobe: Y0..Y9 newly complete
- earlyOutReady  output  1  combinational, one cycle ahead of outReady
- seqError  output  1  sticky beat-order error flag

## Operation
- FSM with two states.
  - LO: awaiting the low half.
  - HI: low half held, awaiting the high half.
- Beat accepted = enable & inReady. No backpressure; every accepted beat is consumed.
- LO, accepted beat with inSeries=0: S0..S4 are written to an internal low buffer; state goes to HI.
- HI, accepted beat with inSeries=1:
  - Y0..Y4 are loaded from the low buffer and Y5..Y9 from S0..S4, at the same edge.
  - outReady goes to 1 at that edge.
  - State returns to LO.
- Y0..Y9 change only at a completion edge. They hold between completions, so a consumer never sees a half-updated vector.
- Data is a signed pass-through; no width change and no arithmetic.
- earlyOutReady = enable & inReady & (state==HI) & (inSeries==1 or check disabled).
- readyForNewDataSeries = (state==LO).
- enable=0: no beat accepted; state, buffer, Y and seqError hold. outReady is driven 0 at the next edge.
- Reset is asserted asynchronously, and recovery is normal on the next edge after reset is released. Reset asserted mid-series discards the pending low half.

## Timing
- Reset values:
  - state = LO
  - low buffer, Y0..Y9 = 0
  - outReady = 0, seqError = 0
  - readyForNewDataSeries = 1
  - earlyOutReady = 0 (inputs permitting)
- Latency:
  - The high beat is accepted at edge N.
  - Y is valid and outReady=1 in the cycle after edge N.
  - outReady deasserts at edge N+1 unless another completion occurs there.
- Back-to-back series: the low beat can arrive in the cycle immediately after the high beat. Sustained throughput is one vector per two accepted beats.
- inReady gaps between beats are allowed with any length; the state waits.

## Configuration
- SERIES_ORDER_CHECK_EN defined:
  - inSeries is honoured and order is checked.
  - inSeries=1 beat while in LO: the beat is dropped, state stays LO, seqError is set.
  - inSeries=0 beat while in HI: the low buffer is overwritten (restart), state stays HI, seqError is set.
  - seqError clears only on reset.
- SERIES_ORDER_CHECK_EN not defined:
  - inSeries is ignored; each accepted beat alternates LO/HI from the internal state.
  - seqError is tied to 0.

## Test plan
- Reset, then low beat S=1,2,3,4,5, then high beat S=6,7,8,9,10 on consecutive cycles:
  - Y0..Y9 = 1..10 one cycle after the high beat.
  - outReady high for exactly 1 cycle.
  - earlyOutReady high during the high-beat cycle.
- Negative extremes, IN_WIDTH=10:
  - Low beat all -1024, high beat all 1023 → Y0..Y4 = -1024, Y5..Y9 = 1023, sign preserved.
- Gaps and enable:
  - Low beat, 3 idle cycles, then the high beat with enable=0 → not accepted, no outReady.
  - Same high beat with enable=1 → completes, outReady on the next cycle.
- Back-to-back: four beats on consecutive cycles giving vectors 1..10 then 11..20:
  - Two outReady strobes spaced 2 cycles apart.
  - Y holds 1..10 until the second strobe.
- Reset mid-series: low beat 1..5, then assert reset → readyForNewDataSeries=1 and Y=0. A following low beat 21..25 and high beat 26..30 give Y = 21..30.
- With SERIES_ORDER_CHECK_EN:
  - High beat in LO → dropped, seqError=1, no outReady.
  - Then a valid low/high pair completes normally; seqError stays 1 until reset.
- Without SERIES_ORDER_CHECK_EN, the same stimulus completes a vector, and seqError stays 0.
